// File: rtl/simplez_core.sv
// SIMPLEZ teaching CPU: 8-instruction ISA, I0/I1/O0/O1 sequencer plus HALT,
// AC/CP/RI datapath talking to an external synchronous single-port memory.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  S_I0  | fetch: present CP, read strobe, CP advances
//  S_I1  | decode incoming word, latch RI, execute 2-cycle instructions
//  S_O0  | operand access at RI.CD (write for ST, read for LD/ADD)
//  S_O1  | operand lands in AC for LD/ADD
//  S_H   | halted; resume pulse restarts fetching at CP
module simplez_core #(
   parameter int                ADDRW    = 9,
   parameter logic [ADDRW-1:0]  RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               resume,
   output logic [ADDRW-1:0]   mem_addr,
   output logic               mem_rd,
   output logic               mem_wr,
   output logic [ADDRW+2:0]   mem_wdata,
   input  logic [ADDRW+2:0]   mem_rdata,
   output logic               stop,
   output logic [ADDRW+2:0]   dbg_ac,
   output logic [ADDRW-1:0]   dbg_pc,
   output logic [ADDRW+2:0]   dbg_ri
);

   localparam int DATAW = ADDRW + 3;

   localparam logic [2:0] OP_ST   = 3'd0;
   localparam logic [2:0] OP_LD   = 3'd1;
   localparam logic [2:0] OP_ADD  = 3'd2;
   localparam logic [2:0] OP_BR   = 3'd3;
   localparam logic [2:0] OP_BZ   = 3'd4;
   localparam logic [2:0] OP_CLR  = 3'd5;
   localparam logic [2:0] OP_DEC  = 3'd6;
   localparam logic [2:0] OP_HALT = 3'd7;

   typedef enum logic [2:0] {S_I0, S_I1, S_O0, S_O1, S_H} state_t;

   state_t             state_q, state_d;
   logic [ADDRW-1:0]   cp_q, cp_d;
   logic [DATAW-1:0]   ac_q, ac_d;
   logic [DATAW-1:0]   ri_q, ri_d;

   logic [2:0]         rd_op, ri_op;
   logic [ADDRW-1:0]   rd_cd, ri_cd;

   assign rd_op = mem_rdata[DATAW-1:ADDRW];
   assign rd_cd = mem_rdata[ADDRW-1:0];
   assign ri_op = ri_q[DATAW-1:ADDRW];
   assign ri_cd = ri_q[ADDRW-1:0];

   always_comb begin
      state_d = state_q;
      cp_d    = cp_q;
      ac_d    = ac_q;
      ri_d    = ri_q;
      case (state_q)
         S_I0: begin
            cp_d    = cp_q + ADDRW'(1);
            state_d = S_I1;
         end
         S_I1: begin
            // decode straight from the bus; RI only becomes valid next cycle
            ri_d    = mem_rdata;
            state_d = S_I0;
            case (rd_op)
               OP_BR:   cp_d = rd_cd;
               OP_BZ:   if (ac_q == '0) cp_d = rd_cd;
               OP_CLR:  ac_d = '0;
               OP_DEC:  ac_d = ac_q - DATAW'(1);
               OP_HALT: state_d = S_H;
               default: state_d = S_O0;
            endcase
         end
         S_O0: state_d = S_O1;
         S_O1: begin
            if (ri_op == OP_LD)  ac_d = mem_rdata;
            if (ri_op == OP_ADD) ac_d = ac_q + mem_rdata;
            state_d = S_I0;
         end
         S_H: if (resume) state_d = S_I0;
         default: state_d = S_I0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= S_I0;
         cp_q    <= RESET_PC;
         ac_q    <= '0;
         ri_q    <= '0;
      end else begin
         state_q <= state_d;
         cp_q    <= cp_d;
         ac_q    <= ac_d;
         ri_q    <= ri_d;
      end
   end

   // strobes are gated by rstn so an aborted ST never reaches memory
   assign mem_addr  = (state_q == S_O0) ? ri_cd : cp_q;
   assign mem_rd    = rstn && ((state_q == S_I0) ||
                      ((state_q == S_O0) && ((ri_op == OP_LD) || (ri_op == OP_ADD))));
   assign mem_wr    = rstn && (state_q == S_O0) && (ri_op == OP_ST);
   assign mem_wdata = ac_q;
   assign stop      = rstn && (state_q == S_H);
   assign dbg_ac    = ac_q;
   assign dbg_pc    = cp_q;
   assign dbg_ri    = ri_q;

endmodule

// File: tb/tb_simplez_core.sv
// Directed bench for simplez_core: default build (ADDRW=9) plus a small
// ADDRW=6 build starting near the top of its address space.
module tb_simplez_core;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // default instance, ADDRW=9 / DATAW=12
   logic        rstn = 1'b0, resume = 1'b0;
   logic [8:0]  mem_addr;
   logic        mem_rd, mem_wr, stop;
   logic [11:0] mem_wdata, mem_rdata, dbg_ac, dbg_ri;
   logic [8:0]  dbg_pc;
   logic [11:0] mem0 [512];
   logic        ld_we0 = 1'b0;
   logic [8:0]  ld_a0  = '0;
   logic [11:0] ld_d0  = '0;

   simplez_core dut (
      .clk(clk), .rstn(rstn), .resume(resume),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stop(stop),
      .dbg_ac(dbg_ac), .dbg_pc(dbg_pc), .dbg_ri(dbg_ri)
   );

   always @(posedge clk) begin
      if (ld_we0)      mem0[ld_a0]    <= ld_d0;
      else if (mem_wr) mem0[mem_addr] <= mem_wdata;
      if (mem_rd)      mem_rdata      <= mem0[mem_addr];
   end

   // small instance, ADDRW=6 / DATAW=9, RESET_PC=60
   logic        rstn2 = 1'b0, resume2 = 1'b0;
   logic [5:0]  mem_addr2;
   logic        mem_rd2, mem_wr2, stop2;
   logic [8:0]  mem_wdata2, mem_rdata2, dbg_ac2, dbg_ri2;
   logic [5:0]  dbg_pc2;
   logic [8:0]  mem1 [64];
   logic        ld_we1 = 1'b0;
   logic [5:0]  ld_a1  = '0;
   logic [8:0]  ld_d1  = '0;

   simplez_core #(.ADDRW(6), .RESET_PC(6'd60)) dut2 (
      .clk(clk), .rstn(rstn2), .resume(resume2),
      .mem_addr(mem_addr2), .mem_rd(mem_rd2), .mem_wr(mem_wr2),
      .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2), .stop(stop2),
      .dbg_ac(dbg_ac2), .dbg_pc(dbg_pc2), .dbg_ri(dbg_ri2)
   );

   always @(posedge clk) begin
      if (ld_we1)       mem1[ld_a1]     <= ld_d1;
      else if (mem_wr2) mem1[mem_addr2] <= mem_wdata2;
      if (mem_rd2)      mem_rdata2      <= mem1[mem_addr2];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load0(input int a, input logic [11:0] d);
      ld_we0 = 1'b1; ld_a0 = 9'(a); ld_d0 = d;
      tick();
      ld_we0 = 1'b0;
   endtask

   task automatic load1(input int a, input logic [8:0] d);
      ld_we1 = 1'b1; ld_a1 = 6'(a); ld_d1 = d;
      tick();
      ld_we1 = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0; resume = 1'b1;
      repeat (3) tick();
      total_cnt++; if (mem_wr !== 1'b0) $display("FAIL rst_mem_wr got %b want 0", mem_wr); else pass_cnt++;
      total_cnt++; if (mem_rd !== 1'b0) $display("FAIL rst_mem_rd got %b want 0", mem_rd); else pass_cnt++;
      total_cnt++; if (stop !== 1'b0) $display("FAIL rst_stop got %b want 0", stop); else pass_cnt++;
      total_cnt++; if (dbg_pc !== 9'd0) $display("FAIL rst_pc got %0d want 0", dbg_pc); else pass_cnt++;
      total_cnt++; if (dbg_ac !== 12'd0) $display("FAIL rst_ac got %h want 000", dbg_ac); else pass_cnt++;
      resume = 1'b0; rstn = 1'b1;
      #1;
      total_cnt++; if (mem_rd !== 1'b1) $display("FAIL first_fetch_rd got %b want 1", mem_rd); else pass_cnt++;
      total_cnt++; if (mem_addr !== 9'd0) $display("FAIL first_fetch_addr got %0d want 0", mem_addr); else pass_cnt++;
   endtask

   // LD 10; ADD 11; ST 12; HALT; HALT  with mem[10]=5, mem[11]=7
   task automatic test_ld_add_st();
      rstn = 1'b0; tick();
      load0(0, 12'h20A); load0(1, 12'h40B); load0(2, 12'h00C);
      load0(3, 12'hE00); load0(4, 12'hE00);
      load0(10, 12'd5);  load0(11, 12'd7);  load0(12, 12'd0);
      rstn = 1'b1;
      repeat (13) tick();
      total_cnt++; if (stop !== 1'b0) $display("FAIL stop_early got %b want 0", stop); else pass_cnt++;
      tick();
      total_cnt++; if (stop !== 1'b1) $display("FAIL stop_cycle15 got %b want 1", stop); else pass_cnt++;
      total_cnt++; if (dbg_ac !== 12'd12) $display("FAIL add_ac got %0d want 12", dbg_ac); else pass_cnt++;
      total_cnt++; if (dbg_pc !== 9'd4) $display("FAIL halt_pc got %0d want 4", dbg_pc); else pass_cnt++;
      total_cnt++; if (mem0[12] !== 12'd12) $display("FAIL st_mem12 got %0d want 12", mem0[12]); else pass_cnt++;
   endtask

   // continues from the halted state left by test_ld_add_st
   task automatic test_halt_resume();
      repeat (50) tick();
      total_cnt++; if (stop !== 1'b1) $display("FAIL hold_stop got %b want 1", stop); else pass_cnt++;
      total_cnt++; if (dbg_pc !== 9'd4) $display("FAIL hold_pc got %0d want 4", dbg_pc); else pass_cnt++;
      total_cnt++; if (dbg_ac !== 12'd12) $display("FAIL hold_ac got %0d want 12", dbg_ac); else pass_cnt++;
      total_cnt++; if (dbg_ri !== 12'hE00) $display("FAIL hold_ri got %h want E00", dbg_ri); else pass_cnt++;
      total_cnt++; if ((mem_rd | mem_wr) !== 1'b0) $display("FAIL hold_strobes got rd=%b wr=%b want 0", mem_rd, mem_wr); else pass_cnt++;
      resume = 1'b1; tick(); resume = 1'b0;
      total_cnt++; if (stop !== 1'b0) $display("FAIL resume_stop got %b want 0", stop); else pass_cnt++;
      total_cnt++; if (mem_addr !== 9'd4 || mem_rd !== 1'b1) $display("FAIL resume_fetch got addr=%0d rd=%b want 4/1", mem_addr, mem_rd); else pass_cnt++;
      repeat (2) tick();
      total_cnt++; if (stop !== 1'b1 || dbg_pc !== 9'd5) $display("FAIL rehalt got stop=%b pc=%0d want 1/5", stop, dbg_pc); else pass_cnt++;
   endtask

   // CLR; DEC; BZ 20; HALT  -> AC all ones, branch not taken
   task automatic test_clr_dec_bz();
      rstn = 1'b0; tick();
      load0(0, 12'hA00); load0(1, 12'hC00); load0(2, 12'h814); load0(3, 12'hE00);
      load0(20, 12'hE00);
      rstn = 1'b1;
      repeat (7) tick();
      total_cnt++; if (stop !== 1'b0) $display("FAIL bz_nt_early got %b want 0", stop); else pass_cnt++;
      tick();
      total_cnt++; if (stop !== 1'b1) $display("FAIL bz_nt_stop got %b want 1", stop); else pass_cnt++;
      total_cnt++; if (dbg_ac !== 12'hFFF) $display("FAIL dec_ac got %h want FFF", dbg_ac); else pass_cnt++;
      total_cnt++; if (dbg_pc !== 9'd4) $display("FAIL bz_nt_pc got %0d want 4", dbg_pc); else pass_cnt++;
   endtask

   // CLR; BZ 20 -> taken
   task automatic test_bz_taken();
      rstn = 1'b0; tick();
      load0(0, 12'hA00); load0(1, 12'h814);
      rstn = 1'b1;
      repeat (2) tick();
      total_cnt++; if (mem_addr !== 9'd1) $display("FAIL bz_fetch_addr got %0d want 1", mem_addr); else pass_cnt++;
      repeat (2) tick();
      total_cnt++; if (dbg_pc !== 9'd20) $display("FAIL bz_taken_pc got %0d want 20", dbg_pc); else pass_cnt++;
      total_cnt++; if (mem_addr !== 9'd20 || mem_rd !== 1'b1) $display("FAIL bz_target_fetch got addr=%0d rd=%b want 20/1", mem_addr, mem_rd); else pass_cnt++;
   endtask

   // DEC; ADD 30; HALT with mem[30]=2 -> FFF+2 wraps to 001
   task automatic test_add_overflow();
      rstn = 1'b0; tick();
      load0(0, 12'hC00); load0(1, 12'h41E); load0(2, 12'hE00); load0(30, 12'h002);
      rstn = 1'b1;
      repeat (8) tick();
      total_cnt++; if (stop !== 1'b1) $display("FAIL ovf_stop got %b want 1", stop); else pass_cnt++;
      total_cnt++; if (dbg_ac !== 12'h001) $display("FAIL ovf_ac got %h want 001", dbg_ac); else pass_cnt++;
   endtask

   // BR 511; CLR at 511 -> CP wraps to 0
   task automatic test_br_wrap();
      rstn = 1'b0; tick();
      load0(0, 12'h7FF); load0(511, 12'hA00);
      rstn = 1'b1;
      repeat (2) tick();
      total_cnt++; if (mem_addr !== 9'd511 || mem_rd !== 1'b1) $display("FAIL br_fetch got addr=%0d rd=%b want 511/1", mem_addr, mem_rd); else pass_cnt++;
      tick();
      total_cnt++; if (dbg_pc !== 9'd0) $display("FAIL pc_wrap got %0d want 0", dbg_pc); else pass_cnt++;
   endtask

   // DEC; ST 12, reset dropped during O0 of the ST
   task automatic test_mid_reset();
      rstn = 1'b0; tick();
      load0(0, 12'hC00); load0(1, 12'h00C); load0(12, 12'h123);
      rstn = 1'b1;
      repeat (4) tick();
      total_cnt++; if (mem_wr !== 1'b1 || mem_addr !== 9'd12) $display("FAIL st_o0 got wr=%b addr=%0d want 1/12", mem_wr, mem_addr); else pass_cnt++;
      total_cnt++; if (mem_wdata !== 12'hFFF) $display("FAIL st_wdata got %h want FFF", mem_wdata); else pass_cnt++;
      rstn = 1'b0;
      #1;
      total_cnt++; if (mem_wr !== 1'b0) $display("FAIL abort_wr got %b want 0", mem_wr); else pass_cnt++;
      tick();
      total_cnt++; if (mem0[12] !== 12'h123) $display("FAIL abort_mem12 got %h want 123", mem0[12]); else pass_cnt++;
      total_cnt++; if (dbg_pc !== 9'd0 || dbg_ac !== 12'd0) $display("FAIL abort_regs got pc=%0d ac=%h want 0/000", dbg_pc, dbg_ac); else pass_cnt++;
      rstn = 1'b1;
      #1;
      total_cnt++; if (mem_rd !== 1'b1 || mem_addr !== 9'd0) $display("FAIL restart_fetch got rd=%b addr=%0d want 1/0", mem_rd, mem_addr); else pass_cnt++;
   endtask

   // LD 10; ADD 11; ST 12; HALT at 60..63, CP wraps 63 -> 0
   task automatic test_small_addr();
      rstn2 = 1'b0; tick();
      total_cnt++; if (dbg_pc2 !== 6'd60) $display("FAIL s_rst_pc got %0d want 60", dbg_pc2); else pass_cnt++;
      load1(60, 9'h04A); load1(61, 9'h08B); load1(62, 9'h00C); load1(63, 9'h1C0);
      load1(10, 9'd5);   load1(11, 9'd7);   load1(12, 9'd0);
      rstn2 = 1'b1;
      repeat (13) tick();
      total_cnt++; if (stop2 !== 1'b0) $display("FAIL s_stop_early got %b want 0", stop2); else pass_cnt++;
      tick();
      total_cnt++; if (stop2 !== 1'b1) $display("FAIL s_stop got %b want 1", stop2); else pass_cnt++;
      total_cnt++; if (dbg_pc2 !== 6'd0) $display("FAIL s_pc_wrap got %0d want 0", dbg_pc2); else pass_cnt++;
      total_cnt++; if (dbg_ac2 !== 9'd12) $display("FAIL s_ac got %0d want 12", dbg_ac2); else pass_cnt++;
      total_cnt++; if (mem1[12] !== 9'd12) $display("FAIL s_mem12 got %0d want 12", mem1[12]); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_ld_add_st();
      test_halt_resume();
      test_clr_dec_bz();
      test_bz_taken();
      test_add_overflow();
      test_br_wrap();
      test_mid_reset();
      test_small_addr();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
